// File: rtl/sdram_port_arbiter.sv
// ---------------------------------------------------------------------------------------------
// sdram_port_arbiter
//
// Shares one 8-bit SDRAM controller port between three requesters using fixed 8-clock slots:
//   p0 = ROM/cart loader, p1 = CPU, p2 = video/aux fetch.
// A free-running 3-bit slot counter defines the slots. On the edge that leaves sc == 7:
//   - sd_clkref toggles, which re-arms the controller's slot edge detector,
//   - the port granted in the slot that just ended receives its one-cycle ack,
//   - a new winner is picked and its request is registered onto the controller outputs.
// After REFRESH_MAX consecutive granted slots, one idle slot is forced so the controller can
// run its auto-refresh. The controller only refreshes on request-free slots.
//
// Optional feature macro: SDRAM_ARB_RR_EN
//   undefined : fixed priority p0 > p1 > p2
//   defined   : p0 keeps absolute priority, and p1/p2 alternate through a one-bit pointer
//
// Parameters
//   REFRESH_MAX  consecutive granted slots before a forced idle slot (1..255)
//   RD_CAPTURE   slot cycle on whose closing edge sd_dout is sampled for reads (0..7)
//
// Ports
//   clk, reset          controller clock, synchronous active-high reset
//   sd_clkref           slot reference, toggles at every slot start
//   sd_oe / sd_we       read / write request, held for a whole granted slot
//   sd_bank, sd_addr    SDRAM bank and byte address of the granted access
//   sd_din / sd_dout    write data to / read data from the controller
//   pN_req, pN_we       request level and direction (1 = write) for port N
//   pN_addr, pN_wdata   {bank, byte address} and write data for port N
//   pN_ack              one-cycle completion pulse, high during sc == 0 after the slot
//   pN_rdata            read data, valid from pN_ack until that port's next ack
// ---------------------------------------------------------------------------------------------
module sdram_port_arbiter #(
    parameter int unsigned REFRESH_MAX = 16,
    parameter int unsigned RD_CAPTURE  = 7
) (
    input  logic        clk,
    input  logic        reset,

    output logic        sd_clkref,
    output logic        sd_oe,
    output logic        sd_we,
    output logic [1:0]  sd_bank,
    output logic [22:0] sd_addr,
    output logic [7:0]  sd_din,
    input  logic [7:0]  sd_dout,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [24:0] p0_addr,
    input  logic [7:0]  p0_wdata,
    output logic        p0_ack,
    output logic [7:0]  p0_rdata,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [24:0] p1_addr,
    input  logic [7:0]  p1_wdata,
    output logic        p1_ack,
    output logic [7:0]  p1_rdata,

    input  logic        p2_req,
    input  logic        p2_we,
    input  logic [24:0] p2_addr,
    input  logic [7:0]  p2_wdata,
    output logic        p2_ack,
    output logic [7:0]  p2_rdata
);

    localparam logic [2:0] RdCap  = 3'(RD_CAPTURE);
    localparam logic [7:0] RefMax = 8'(REFRESH_MAX);

    // Requester inputs gathered into indexable form.
    logic [2:0]  req;
    logic [2:0]  wr;
    logic [24:0] addr  [3];
    logic [7:0]  wdata [3];

    assign req      = {p2_req, p1_req, p0_req};
    assign wr       = {p2_we, p1_we, p0_we};
    assign addr[0]  = p0_addr;
    assign addr[1]  = p1_addr;
    assign addr[2]  = p2_addr;
    assign wdata[0] = p0_wdata;
    assign wdata[1] = p1_wdata;
    assign wdata[2] = p2_wdata;

    // State
    logic [2:0]       sc_q, sc_d;
    logic             clkref_q, clkref_d;
    logic             oe_q, oe_d;
    logic             we_q, we_d;
    logic [1:0]       bank_q, bank_d;
    logic [22:0]      addr_q, addr_d;
    logic [7:0]       din_q, din_d;
    logic             gnt_vld_q, gnt_vld_d;
    logic [1:0]       gnt_port_q, gnt_port_d;
    logic [2:0]       ack_q, ack_d;
    logic [2:0][7:0]  rdata_q, rdata_d;
    logic [7:0]       busy_q, busy_d;
`ifdef SDRAM_ARB_RR_EN
    // 0 = prefer p1, 1 = prefer p2
    logic             rr_q, rr_d;
`endif

    // Arbitration helpers
    logic       slot_end;
    logic [2:0] ack_now;
    logic [2:0] elig;
    logic       force_idle;
    logic       win_vld;
    logic [1:0] win_port;

    always_comb begin
        slot_end = (sc_q == 3'd7);
        ack_now  = 3'b000;
        if (slot_end && gnt_vld_q) begin
            unique case (gnt_port_q)
                2'd0:    ack_now = 3'b001;
                2'd1:    ack_now = 3'b010;
                default: ack_now = 3'b100;
            endcase
        end
        // A port whose ack is issued on this edge still has its old req high; excluding it
        // keeps one request from being granted twice.
        elig       = req & ~ack_now;
        force_idle = (busy_q >= RefMax);
    end

    always_comb begin
        win_vld  = 1'b0;
        win_port = 2'd0;
        if (!force_idle) begin
            if (elig[0]) begin
                win_vld  = 1'b1;
                win_port = 2'd0;
            end
`ifdef SDRAM_ARB_RR_EN
            else if (elig[1] && elig[2]) begin
                win_vld  = 1'b1;
                win_port = rr_q ? 2'd2 : 2'd1;
            end
`endif
            else if (elig[1]) begin
                win_vld  = 1'b1;
                win_port = 2'd1;
            end else if (elig[2]) begin
                win_vld  = 1'b1;
                win_port = 2'd2;
            end
        end
    end

    always_comb begin
        sc_d       = sc_q + 3'd1;
        clkref_d   = clkref_q;
        oe_d       = oe_q;
        we_d       = we_q;
        bank_d     = bank_q;
        addr_d     = addr_q;
        din_d      = din_q;
        gnt_vld_d  = gnt_vld_q;
        gnt_port_d = gnt_port_q;
        ack_d      = 3'b000;
        rdata_d    = rdata_q;
        busy_d     = busy_q;
`ifdef SDRAM_ARB_RR_EN
        rr_d       = rr_q;
`endif

        if (gnt_vld_q && oe_q && (sc_q == RdCap)) begin
            rdata_d[gnt_port_q] = sd_dout;
        end

        if (slot_end) begin
            clkref_d   = ~clkref_q;
            ack_d      = ack_now;
            gnt_vld_d  = win_vld;
            gnt_port_d = win_port;
            if (win_vld) begin
                we_d   = wr[win_port];
                oe_d   = ~wr[win_port];
                bank_d = addr[win_port][24:23];
                addr_d = addr[win_port][22:0];
                din_d  = wdata[win_port];
                busy_d = busy_q + 8'd1;
`ifdef SDRAM_ARB_RR_EN
                if (win_port == 2'd1) begin
                    rr_d = 1'b1;
                end else if (win_port == 2'd2) begin
                    rr_d = 1'b0;
                end
`endif
            end else begin
                // Idle slot: address and data registers keep their last values.
                oe_d   = 1'b0;
                we_d   = 1'b0;
                busy_d = 8'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sc_q       <= 3'd0;
            clkref_q   <= 1'b0;
            oe_q       <= 1'b0;
            we_q       <= 1'b0;
            bank_q     <= 2'd0;
            addr_q     <= 23'd0;
            din_q      <= 8'd0;
            gnt_vld_q  <= 1'b0;
            gnt_port_q <= 2'd0;
            ack_q      <= 3'b000;
            rdata_q    <= '0;
            busy_q     <= 8'd0;
`ifdef SDRAM_ARB_RR_EN
            rr_q       <= 1'b0;
`endif
        end else begin
            sc_q       <= sc_d;
            clkref_q   <= clkref_d;
            oe_q       <= oe_d;
            we_q       <= we_d;
            bank_q     <= bank_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            gnt_vld_q  <= gnt_vld_d;
            gnt_port_q <= gnt_port_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
`ifdef SDRAM_ARB_RR_EN
            rr_q       <= rr_d;
`endif
        end
    end

    assign sd_clkref = clkref_q;
    assign sd_oe     = oe_q;
    assign sd_we     = we_q;
    assign sd_bank   = bank_q;
    assign sd_addr   = addr_q;
    assign sd_din    = din_q;

    assign p0_ack    = ack_q[0];
    assign p1_ack    = ack_q[1];
    assign p2_ack    = ack_q[2];
    assign p0_rdata  = rdata_q[0];
    assign p1_rdata  = rdata_q[1];
    assign p2_rdata  = rdata_q[2];

endmodule
